// File: rtl/irq_excp_ctrl.sv
// Interrupt/exception controller: latches IRQ lines, masks, arbitrates against excp,
// and runs a req/ack/eret handshake. Define IRQ_LEVEL_EN for level-sensitive irq_in.
module irq_excp_ctrl #(
  parameter int N_IRQ  = 4,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              excp,
  input  logic              monin,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  input  logic              irq_ack,
  input  logic              eret,
  output logic              irq_req,
  output logic [CODE_W-1:0] irq_code,
  output logic [N_IRQ-1:0]  mask_o,
  output logic [N_IRQ-1:0]  pending_o,
  output logic              in_service,
  output logic              dbl_fault
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e              state_q, state_d;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic [N_IRQ-1:0]    mask_q, mask_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                dbl_fault_q, dbl_fault_d;
  logic [CODE_W-1:0]   cand_code;
`ifndef IRQ_LEVEL_EN
  logic [N_IRQ-1:0]    irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]    clr;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    cand_code   = '0;
    state_d     = state_q;
    code_d      = code_q;
    dbl_fault_d = dbl_fault_q;
    mask_d      = mask_we ? mask_wdata : mask_q;

    // Descending scan so the lowest enabled pending line wins; excp overrides all lines.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i] && mask_q[i]) cand_code = CODE_W'(i + 2);
    end
    if (excp) cand_code = CODE_W'(1);

    case (state_q)
      IDLE: begin
        if (!monin && cand_code != '0) begin
          state_d = REQ;
          code_d  = cand_code;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SERVICE;
          code_d  = '0;
        end
      end
      SERVICE: begin
        if (excp) dbl_fault_d = 1'b1;
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef IRQ_LEVEL_EN
    pending_d = irq_in;
`else
    clr = '0;
    if (state_q == REQ && irq_ack) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (code_q == CODE_W'(i + 2)) clr[i] = 1'b1;
      end
    end
    // Clear first, then OR in new edges: a same-cycle set wins over the ack clear.
    pending_d  = (pending_q & ~clr) | (irq_in & ~irq_prev_q);
    irq_prev_d = irq_in;
`endif
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mask_q      <= '1;
      code_q      <= '0;
      dbl_fault_q <= 1'b0;
`ifndef IRQ_LEVEL_EN
      irq_prev_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      code_q      <= code_d;
      dbl_fault_q <= dbl_fault_d;
`ifndef IRQ_LEVEL_EN
      irq_prev_q  <= irq_prev_d;
`endif
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_code   = code_q;
  assign mask_o     = mask_q;
  assign pending_o  = pending_q;
  assign dbl_fault  = dbl_fault_q;

endmodule

// File: tb/tb_irq_excp_ctrl.sv
// Self-checking bench for irq_excp_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_irq_excp_ctrl;
  localparam int N_IRQ  = 4;
  localparam int CODE_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IRQ-1:0]  irq_in;
  logic              excp, monin, mask_we, irq_ack, eret;
  logic [N_IRQ-1:0]  mask_wdata;
  logic              irq_req, in_service, dbl_fault;
  logic [CODE_W-1:0] irq_code;
  logic [N_IRQ-1:0]  mask_o, pending_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a request is "outstanding code c" (0 = none), a handler is
  // either running or not; pending/mask are plain bit sets.
  int               m_req_code;
  bit               m_handler;
  bit               m_dbl;
  bit [N_IRQ-1:0]   m_pending, m_mask, m_last_in;

  irq_excp_ctrl #(.N_IRQ(N_IRQ), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .excp(excp), .monin(monin),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eret(eret),
    .irq_req(irq_req), .irq_code(irq_code), .mask_o(mask_o), .pending_o(pending_o),
    .in_service(in_service), .dbl_fault(dbl_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs that the DUT samples.
  task automatic model_step();
    bit [N_IRQ-1:0] np;
    int             cand;
    if (reset) begin
      m_req_code = 0; m_handler = 0; m_dbl = 0;
      m_pending = '0; m_mask = '1; m_last_in = '0;
      return;
    end
`ifdef IRQ_LEVEL_EN
    np = irq_in;
`else
    np = m_pending;
    if (m_req_code >= 2 && irq_ack) np[m_req_code - 2] = 1'b0;
    np = np | (irq_in & ~m_last_in);
`endif
    if (m_req_code != 0) begin
      if (irq_ack) begin m_req_code = 0; m_handler = 1; end
    end else if (m_handler) begin
      if (excp) m_dbl = 1;
      if (eret) m_handler = 0;
    end else if (!monin) begin
      cand = 0;
      if (excp) cand = 1;
      else
        for (int i = 0; i < N_IRQ; i++)
          if (cand == 0 && m_pending[i] && m_mask[i]) cand = i + 2;
      m_req_code = cand;
    end
    if (mask_we) m_mask = mask_wdata;
    m_pending = np;
    m_last_in = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq_req",    irq_req,    m_req_code != 0);
    check("irq_code",   irq_code,   m_req_code);
    check("in_service", in_service, m_handler);
    check("dbl_fault",  dbl_fault,  m_dbl);
    check("mask_o",     mask_o,     m_mask);
    check("pending_o",  pending_o,  m_pending);
  endtask

  task automatic clear_inputs();
    irq_in = '0; excp = 0; monin = 0; mask_we = 0; mask_wdata = '0;
    irq_ack = 0; eret = 0; reset = 0;
  endtask

  task automatic ack_and_return();
    irq_ack = 1; tick(); irq_ack = 0;
    eret = 1; tick(); eret = 0;
  endtask

  initial begin
    clear_inputs();
    m_req_code = 0; m_handler = 0; m_dbl = 0;
    m_pending = '0; m_mask = '1; m_last_in = '0;
    reset = 1; tick(); tick(); reset = 0;
    check("rst_mask", mask_o, 4'hF);
    check("rst_req", irq_req, 0);

    // Single pulse on line 2
    irq_in = 4'b0100; tick();
    check("t1_pending", pending_o, 4'b0100);
    irq_in = '0; tick();
    check("t1_code", irq_code, 4);
    irq_ack = 1; tick(); irq_ack = 0;
    check("t1_svc", in_service, 1);
    check("t1_pend_clr", pending_o, 0);
    eret = 1; tick(); eret = 0;
    check("t1_idle", in_service, 0);

    // Lines 1 and 3 together: lowest index first
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    check("t2_first", irq_code, 3);
    ack_and_return(); tick();
    check("t2_second", irq_code, 5);
    ack_and_return();

    // Exception wins over simultaneous line 0 edge
    irq_in = 4'b0001; excp = 1; tick(); irq_in = '0; excp = 0;
    check("t3_excp", irq_code, 1);
    irq_ack = 1; tick(); irq_ack = 0;
    check("t3_pend0", pending_o[0], 1);
    eret = 1; tick(); eret = 0; tick();
    check("t3_line0", irq_code, 2);
    ack_and_return();

    // Masked line stays pending, unmask releases it
    mask_we = 1; mask_wdata = 4'b1110; tick(); mask_we = 0;
    irq_in = 4'b0001; tick(); irq_in = '0; tick(); tick();
    check("t4_pend", pending_o[0], 1);
    check("t4_noreq", irq_req, 0);
    mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0; tick();
    check("t4_code", irq_code, 2);
    ack_and_return();

    // monin holds off; drop it and the request follows next cycle
    monin = 1; irq_in = 4'b0010; tick(); irq_in = '0; tick(); tick();
    check("t5_held", irq_req, 0);
    monin = 0; tick();
    check("t5_code", irq_code, 3);
    irq_ack = 1; tick(); irq_ack = 0;
    excp = 1; tick(); excp = 0;
    check("t5_dbl", dbl_fault, 1);
    eret = 1; tick(); eret = 0; tick();
    check("t5_dbl_sticky", dbl_fault, 1);
    irq_in = 4'b0001; tick(); irq_in = '0; tick();
    check("t6_inreq", irq_req, 1);
    reset = 1; tick(); reset = 0;
    check("t6_rst_req", irq_req, 0);
    check("t6_rst_code", irq_code, 0);
    check("t6_rst_dbl", dbl_fault, 0);
    check("t6_rst_pend", pending_o, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq_in     = N_IRQ'($urandom) & N_IRQ'($urandom);
      excp       = ($urandom_range(0, 15) == 0);
      monin      = ($urandom_range(0, 3) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = N_IRQ'($urandom);
      irq_ack    = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
